// File: rtl/minterm_sweeper.sv
// rtl/minterm_sweeper.sv - sweeps a 3-input dual-rail function block and captures its truth table
module minterm_sweeper #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F_in,
    input  logic       Fn_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic [3:0] err_cnt,
    output logic [2:0] first_bad
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_LAST_CNT = 4'(SETTLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_idx;
    logic [3:0] r_cnt;
    logic [7:0] r_tt;
    logic [3:0] r_err_cnt;
    logic [2:0] r_first_bad;
    logic       w_active;
    logic       w_rail_bad;

    assign w_active   = (r_state == S_DRIVE) || (r_state == S_SAMPLE);
    assign w_rail_bad = (F_in == Fn_in);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_DRIVE;
            S_DRIVE:  if (r_cnt == LP_LAST_CNT) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_idx == 3'd7) ? S_DONE : S_DRIVE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 3'd0;
            r_cnt       <= 4'd0;
            r_tt        <= 8'h00;
            r_err_cnt   <= 4'd0;
            r_first_bad <= 3'd0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx       <= 3'd0;
                        r_cnt       <= 4'd0;
                        r_tt        <= 8'h00;
                        r_err_cnt   <= 4'd0;
                        r_first_bad <= 3'd0;
                    end
                end
                S_DRIVE: r_cnt <= r_cnt + 4'd1;
                S_SAMPLE: begin
                    r_tt[r_idx] <= F_in;
                    // first_bad latches only the earliest violation of the sweep
                    if (w_rail_bad) begin
                        r_err_cnt <= r_err_cnt + 4'd1;
                        if (r_err_cnt == 4'd0) r_first_bad <= r_idx;
                    end
                    if (r_idx != 3'd7) begin
                        r_idx <= r_idx + 3'd1;
                        r_cnt <= 4'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {x, y, z}  = w_active ? r_idx : 3'd0;
    assign busy       = w_active;
    assign done       = (r_state == S_DONE);
    assign tt         = r_tt;
    assign err_cnt    = r_err_cnt;
    assign first_bad  = r_first_bad;

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb/tb_minterm_sweeper.sv - randomized model-checked bench for minterm_sweeper at two settle times
module tb_minterm_sweeper;

    localparam int SV0 = 1;
    localparam int SV1 = 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] x, y, z, busy, done, fi, fni;
    logic [7:0] tt [2];
    logic [3:0] ec [2];
    logic [2:0] fb [2];

    logic [7:0] ftab;
    logic [7:0] bad_mask;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit cmp_en = 0;

    int         mk     [2] = '{-1, -1};
    logic [7:0] mtt    [2] = '{8'h00, 8'h00};
    int         merr   [2] = '{0, 0};
    int         mfb    [2] = '{0, 0};
    int         mstart [2] = '{0, 0};

    minterm_sweeper #(.SETTLE_CYCLES(SV0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .F_in(fi[0]), .Fn_in(fni[0]),
        .x(x[0]), .y(y[0]), .z(z[0]), .busy(busy[0]), .done(done[0]),
        .tt(tt[0]), .err_cnt(ec[0]), .first_bad(fb[0])
    );

    minterm_sweeper #(.SETTLE_CYCLES(SV1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .F_in(fi[1]), .Fn_in(fni[1]),
        .x(x[1]), .y(y[1]), .z(z[1]), .busy(busy[1]), .done(done[1]),
        .tt(tt[1]), .err_cnt(ec[1]), .first_bad(fb[1])
    );

    // Function block under test: F from ftab, Fn complementary except where bad_mask marks a fault
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            fi[i]  = ftab[{x[i], y[i], z[i]}];
            fni[i] = bad_mask[{x[i], y[i], z[i]}] ? fi[i] : ~fi[i];
        end
    end

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int per_of(input int i);
        return ((i == 0) ? SV0 : SV1) + 1;
    endfunction

    task automatic chk(input int inst, input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL u%0d %s: got %0d expected %0d (cycle %0d)", inst, nm, act, exp, cyc);
        end
    endtask

    // Reference model: position within a sweep is just cycles elapsed since the accepting edge
    always @(posedge clk) begin
        int p, idx;
        logic f, fn;
        cyc++;
        cmp_en = 1;
        for (int i = 0; i < 2; i++) begin
            p = per_of(i);
            if (rst) begin
                mk[i] = -1; mtt[i] = 8'h00; merr[i] = 0; mfb[i] = 0;
            end else if (mk[i] < 0) begin
                if (start) begin
                    mk[i] = 0; mtt[i] = 8'h00; merr[i] = 0; mfb[i] = 0; mstart[i] = cyc;
                end
            end else if (mk[i] < 8 * p) begin
                if (mk[i] % p == p - 1) begin
                    idx = mk[i] / p;
                    f   = ftab[idx];
                    fn  = bad_mask[idx] ? f : ~f;
                    mtt[i][idx] = f;
                    if (f == fn) begin
                        if (merr[i] == 0) mfb[i] = idx;
                        merr[i]++;
                    end
                end
                mk[i]++;
            end else begin
                mk[i] = -1;
            end
        end
    end

    always @(negedge clk) begin
        int p, eb, ed, ex;
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                p  = per_of(i);
                eb = (mk[i] >= 0 && mk[i] < 8 * p) ? 1 : 0;
                ed = (mk[i] == 8 * p) ? 1 : 0;
                ex = eb ? mk[i] / p : 0;
                chk(i, "busy", int'(busy[i]), eb);
                chk(i, "done", int'(done[i]), ed);
                chk(i, "xyz", int'({x[i], y[i], z[i]}), ex);
                chk(i, "tt", int'(tt[i]), int'(mtt[i]));
                chk(i, "err_cnt", int'(ec[i]), merr[i]);
                if (merr[i] != 0) chk(i, "first_bad", int'(fb[i]), mfb[i]);
                if (done[i]) chk(i, "done_latency", cyc - mstart[i], 8 * p);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy != 2'b00 || done != 2'b00) && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) chk(0, "idle_timeout", n, -1);
        tick(1);
    endtask

    task automatic run_sweep(input logic [7:0] ft, input logic [7:0] bm);
        ftab = ft;
        bad_mask = bm;
        pulse_start();
        wait_idle(200);
    endtask

    initial begin
        int n;
        rst = 1; start = 0; ftab = 8'h5C; bad_mask = 8'h00;
        tick(3);
        rst = 0;
        tick(2);

        run_sweep(8'h5C, 8'h00);
        chk(0, "pin_tt_good", int'(tt[0]), 8'h5C);
        chk(0, "pin_err_good", int'(ec[0]), 0);
        chk(0, "pin_model_tt", int'(mtt[0]), 8'h5C);
        chk(1, "pin_tt_settle4", int'(tt[1]), 8'h5C);

        run_sweep(8'h5C, 8'hFF);
        chk(0, "pin_tt_allbad", int'(tt[0]), 8'h5C);
        chk(0, "pin_err_allbad", int'(ec[0]), 8);
        chk(0, "pin_fb_allbad", int'(fb[0]), 0);

        run_sweep(8'h5C, 8'h20);
        chk(0, "pin_err_idx5", int'(ec[0]), 1);
        chk(0, "pin_fb_idx5", int'(fb[0]), 5);
        chk(1, "pin_fb_idx5", int'(fb[1]), 5);

        ftab = 8'h5C; bad_mask = 8'h00;
        pulse_start();
        n = 0;
        while (!(busy[0] && {x[0], y[0], z[0]} == 3'd3) && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) chk(0, "idx3_timeout", n, -1);
        rst = 1;
        tick(1);
        rst = 0;
        chk(0, "pin_rst_busy", int'(busy[0]), 0);
        chk(0, "pin_rst_tt", int'(tt[0]), 0);
        chk(0, "pin_rst_done", int'(done[0]), 0);
        tick(2);
        run_sweep(8'h5C, 8'h00);
        chk(0, "pin_tt_after_rst", int'(tt[0]), 8'h5C);

        ftab = 8'hA7; bad_mask = 8'h12;
        pulse_start();
        tick(3);
        pulse_start();
        tick(5);
        pulse_start();
        start = 1;
        tick(70);
        start = 0;
        wait_idle(200);

        for (int it = 0; it < 30; it++) begin
            ftab = 8'($urandom);
            bad_mask = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            tick($urandom_range(0, 3));
            pulse_start();
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(0, 30));
                pulse_start();
            end
            if ($urandom_range(0, 4) == 0) begin
                tick($urandom_range(0, 40));
                rst = 1;
                tick(1);
                rst = 0;
            end
            wait_idle(200);
        end

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minterm_sweeper.md
Name: minterm_sweeper

Overview:
- Sequential stimulus/capture stage wrapped around a 3-input combinational function block with dual-rail outputs F/Fn.
- On a start request it drives every input combination x,y,z = 000..111 in ascending order and waits a programmable settle time on each.
- It then samples F and Fn into an 8-bit truth-table register and counts rail-consistency violations (F == Fn).
- Provides self-test and characterisation of the function block in the same design.

Parameters:
- SETTLE_CYCLES, 1, cycles each combination is held before sampling; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  sweep request, sampled in IDLE only.
- F_in  input  1  F output of the function block.
- Fn_in  input  1  Fn output of the function block.
- x  output  1  function input x, MSB of combination index.
- y  output  1  function input y.
- z  output  1  function input z, LSB.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse at sweep completion.
- tt  output  8  captured truth table; tt[i] = F for index i = {x,y,z}.
- err_cnt  output  4  number of indices where F_in == Fn_in (0..8).
- first_bad  output  3  index of the first violation; valid only when err_cnt != 0.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). All state updates occur on rising clk.
- Reset values: x=y=z=0, busy=0, done=0, tt=8'h00, err_cnt=0, first_bad=0; state IDLE, idx=0, settle counter=0.
- rst has priority over every other input at any time, including mid-sweep. The sweep is abandoned with no done pulse, and all outputs return to reset values on the next edge.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - x,y,z=0, busy=0.
  - If start=1 at an edge: go to DRIVE, idx=0, settle counter=0, clear tt, err_cnt and first_bad.
- DRIVE:
  - {x,y,z}=idx (registered), busy=1.
  - Settle counter increments each cycle. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle):
  - {x,y,z} still equals idx, busy=1.
  - At the edge leaving SAMPLE: tt[idx] <= F_in.
  - If F_in == Fn_in: err_cnt <= err_cnt+1, and first_bad <= idx if err_cnt was 0.
  - If idx==7, go to DONE; else idx <= idx+1, counter <= 0, go to DRIVE.
- DONE (one cycle):
  - done=1, busy=0, x,y,z=0.
  - Unconditionally go to IDLE. start is ignored in DONE.
- Timing:
  - Per combination: SETTLE_CYCLES+1 cycles.
  - With start accepted at edge E, DONE is entered at edge E + 8*(SETTLE_CYCLES+1), and done is high for exactly the following cycle.
- start while busy or in DONE is ignored; no queuing.
- start held high continuously begins a new sweep on the first edge in IDLE, i.e. one cycle after done.
- tt, err_cnt and first_bad hold their values after done until the next accepted start or rst.
- Intermediate tt bits may be read during a sweep but are valid only after done.
- err_cnt is 4 bits so that 8 violations never wrap.
- F_in/Fn_in are sampled only in SAMPLE; values during DRIVE are don't-care.

Test Plan:
- Reset, then start pulse with the function F=1 for minterms 2,3,4,6 and Fn=~F, SETTLE_CYCLES=1 -> x,y,z step 000..111, done pulses 16 cycles after the start edge, tt=8'h5C, err_cnt=0, busy low afterwards.
- Same stimulus with Fn_in tied to F_in -> tt=8'h5C, err_cnt=8, first_bad=0.
- Fn_in forced equal to F_in only at index 5 -> err_cnt=1, first_bad=3'd5, tt=8'h5C.
- rst asserted for one cycle while idx=3 in DRIVE -> next cycle all outputs at reset values and no done pulse; a fresh start yields a full correct sweep.
- start re-pulsed while busy, plus start held high through done -> mid-sweep pulses ignored (single done at the expected cycle); held start launches a second sweep the cycle after done, with tt cleared at launch.
- SETTLE_CYCLES=4 -> each combination held 5 cycles, done at start edge + 40, tt=8'h5C.
